// File: rtl/region_copy_engine.sv
// rtl/region_copy_engine.sv - COPY/FILL region mover with FIFO-decoupled read and write engines
module region_copy_engine #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              go,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] src_stride,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_written,
  output logic [ADDR_W-1:0] src_ptr,
  output logic              src_r_en,
  output logic              src_avail,
  input  logic              src_done,
  input  logic [DATA_W-1:0] src_data_load,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              dst_w_en,
  output logic              dst_avail,
  output logic              dst_write_through,
  input  logic              dst_done,
  output logic [DATA_W-1:0] dst_data_store
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  state_e state_q, state_d;

  logic              mode_q;
  logic [ADDR_W-1:0] stride_q, src_ptr_q, dst_ptr_q;
  logic [LEN_W-1:0]  len_q, rd_cnt_q, words_written_q;
  logic [DATA_W-1:0] fill_q;
  logic              src_avail_q, dst_avail_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [DATA_W-1:0] fifo_mem [BUF_DEPTH];

  logic push, pop, rd_issue, wr_issue, job_start;

  assign job_start = (state_q == S_IDLE) && go;
  assign push      = src_avail_q && src_done;
  assign pop       = dst_avail_q && dst_done && !mode_q;
  // A new request is only considered once the previous one has dropped avail for a cycle.
  assign rd_issue  = !src_avail_q && !mode_q && (rd_cnt_q < len_q) && (fifo_cnt_q < DEPTH_C);
  assign wr_issue  = !dst_avail_q && (words_written_q < len_q) && (mode_q || fifo_cnt_q != '0);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go) state_d = (len != '0) ? S_RUN : S_DONE;
      S_RUN:  if (words_written_q == len_q && !src_avail_q && !dst_avail_q) state_d = S_DONE;
      S_DONE: if (!go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mode_q          <= 1'b0;
      stride_q        <= '0;
      len_q           <= '0;
      fill_q          <= '0;
      src_ptr_q       <= '0;
      dst_ptr_q       <= '0;
      rd_cnt_q        <= '0;
      words_written_q <= '0;
      src_avail_q     <= 1'b0;
      dst_avail_q     <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
    end else if (job_start) begin
      mode_q          <= mode;
      stride_q        <= src_stride;
      len_q           <= len;
      fill_q          <= fill_value;
      src_ptr_q       <= src_base;
      dst_ptr_q       <= dst_base;
      rd_cnt_q        <= '0;
      words_written_q <= '0;
      src_avail_q     <= !mode && (len != '0);
      dst_avail_q     <= mode && (len != '0);
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
    end else if (state_q == S_RUN) begin
      if (src_avail_q) begin
        if (src_done) begin
          src_avail_q <= 1'b0;
          src_ptr_q   <= src_ptr_q + stride_q;
          rd_cnt_q    <= rd_cnt_q + LEN_W'(1);
        end
      end else if (rd_issue) begin
        src_avail_q <= 1'b1;
      end
      if (dst_avail_q) begin
        if (dst_done) begin
          dst_avail_q     <= 1'b0;
          dst_ptr_q       <= dst_ptr_q + ADDR_W'(1);
          words_written_q <= words_written_q + LEN_W'(1);
        end
      end else if (wr_issue) begin
        dst_avail_q <= 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= src_data_load;
  end

  assign words_written     = words_written_q;
  assign src_ptr           = src_ptr_q;
  assign src_avail         = src_avail_q;
  assign src_r_en          = src_avail_q;
  assign dst_ptr           = dst_ptr_q;
  assign dst_avail         = dst_avail_q;
  assign dst_w_en          = dst_avail_q;
  assign dst_write_through = dst_avail_q && (words_written_q == len_q - LEN_W'(1));
  assign dst_data_store    = !dst_avail_q ? '0 : (mode_q ? fill_q : fifo_mem[rd_ptr_q]);
endmodule

// File: tb/tb_region_copy_engine.sv
// tb/tb_region_copy_engine.sv - scoreboard bench for region_copy_engine with latency-programmable memory models
module tb_region_copy_engine;
  logic        clk = 1'b0;
  logic        rst_l, go, mode;
  logic [31:0] src_base, src_stride, dst_base, fill_value;
  logic [15:0] len;
  logic        busy, done;
  logic [15:0] words_written;
  logic [31:0] src_ptr, dst_ptr, dst_data_store, src_data_load;
  logic        src_r_en, src_avail, src_done;
  logic        dst_w_en, dst_avail, dst_write_through, dst_done;

  int n_checks = 0;
  int n_fail   = 0;
  int src_lat  = 1;
  int dst_lat  = 1;
  int src_seen = 0;
  int dst_seen = 0;
  int rd_done_n = 0;
  int wr_done_n = 0;
  logic [31:0] rd_q[$];
  logic [64:0] wr_q[$];

  region_copy_engine dut (
    .clk(clk), .rst_l(rst_l), .go(go), .mode(mode),
    .src_base(src_base), .src_stride(src_stride), .dst_base(dst_base),
    .len(len), .fill_value(fill_value),
    .busy(busy), .done(done), .words_written(words_written),
    .src_ptr(src_ptr), .src_r_en(src_r_en), .src_avail(src_avail),
    .src_done(src_done), .src_data_load(src_data_load),
    .dst_ptr(dst_ptr), .dst_w_en(dst_w_en), .dst_avail(dst_avail),
    .dst_write_through(dst_write_through), .dst_done(dst_done),
    .dst_data_store(dst_data_store)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Source memory: answers each request after src_lat cycles with a one-cycle done.
  initial begin
    int cnt;
    logic [31:0] e;
    cnt = 0;
    src_done = 1'b0;
    src_data_load = '0;
    forever begin
      @(negedge clk);
      if (!rst_l || src_done) begin
        src_done = 1'b0;
        cnt = 0;
      end else if (src_avail) begin
        src_seen++;
        if (cnt >= src_lat) begin
          if (rd_q.size() == 0) check_eq("src_unexpected", 64'(1), 64'(0));
          else begin
            e = rd_q.pop_front();
            check_eq("src_ptr", 64'(src_ptr), 64'(e));
          end
          check_eq("src_r_en", 64'(src_r_en), 64'(1));
          src_data_load = src_word(src_ptr);
          src_done = 1'b1;
          rd_done_n++;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    int cnt;
    logic [64:0] e;
    cnt = 0;
    dst_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_l || dst_done) begin
        dst_done = 1'b0;
        cnt = 0;
      end else if (dst_avail) begin
        dst_seen++;
        if (cnt >= dst_lat) begin
          if (wr_q.size() == 0) check_eq("dst_unexpected", 64'(1), 64'(0));
          else begin
            e = wr_q.pop_front();
            check_eq("dst_ptr", 64'(dst_ptr), 64'(e[63:32]));
            check_eq("dst_data", 64'(dst_data_store), 64'(e[31:0]));
            check_eq("dst_write_through", 64'(dst_write_through), 64'(e[64]));
          end
          check_eq("dst_w_en", 64'(dst_w_en), 64'(1));
          dst_done = 1'b1;
          wr_done_n++;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_busy"}, 64'(busy), 64'(0));
    check_eq({pfx, "_done"}, 64'(done), 64'(0));
    check_eq({pfx, "_words_written"}, 64'(words_written), 64'(0));
    check_eq({pfx, "_src_ptr"}, 64'(src_ptr), 64'(0));
    check_eq({pfx, "_src_handshake"}, 64'({src_r_en, src_avail}), 64'(0));
    check_eq({pfx, "_dst_ptr"}, 64'(dst_ptr), 64'(0));
    check_eq({pfx, "_dst_handshake"}, 64'({dst_w_en, dst_avail, dst_write_through}), 64'(0));
    check_eq({pfx, "_dst_data"}, 64'(dst_data_store), 64'(0));
  endtask

  task automatic start_job(input logic m, input logic [31:0] sb, input logic [31:0] st,
                           input logic [31:0] db, input logic [15:0] n, input logic [31:0] fv);
    int ni;
    logic [31:0] a;
    ni = int'(n);
    for (int i = 0; i < ni; i++) begin
      a = sb + st * 32'(i);
      if (!m) rd_q.push_back(a);
      wr_q.push_back({(i == ni - 1), db + 32'(i), m ? fv : src_word(a)});
    end
    mode = m; src_base = sb; src_stride = st; dst_base = db; len = n; fill_value = fv;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    mode = ~m; src_base = ~sb; src_stride = st + 32'd7; dst_base = ~db; len = n + 16'd3; fill_value = ~fv;
    check_eq("busy_start", 64'(busy), 64'(n != 16'd0));
  endtask

  task automatic wait_done(input logic [15:0] n);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", 64'(done), 64'(1));
    check_eq("words_written", 64'(words_written), 64'(n));
    check_eq("busy_in_done", 64'(busy), 64'(0));
    check_eq("rd_q_drained", 64'(rd_q.size()), 64'(0));
    check_eq("wr_q_drained", 64'(wr_q.size()), 64'(0));
    @(negedge clk);
    check_eq("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int s0, d0, r0, w0, k;
    rst_l = 1'b0; go = 1'b0; mode = 1'b0;
    src_base = '0; src_stride = '0; dst_base = '0; len = '0; fill_value = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    start_job(1'b0, 32'h100, 32'd1, 32'h200, 16'd5, 32'h0);
    wait_done(16'd5);

    start_job(1'b0, 32'hFFFF_FFF8, 32'd4, 32'h300, 16'd3, 32'h0);
    wait_done(16'd3);

    s0 = src_seen;
    start_job(1'b1, 32'h500, 32'd1, 32'h400, 16'd4, 32'hDEAD_BEEF);
    wait_done(16'd4);
    check_eq("fill_no_src", 64'(src_seen - s0), 64'(0));

    s0 = src_seen; d0 = dst_seen;
    len = 16'd0; go = 1'b1;
    @(negedge clk);
    check_eq("len0_done", 64'(done), 64'(1));
    check_eq("len0_busy", 64'(busy), 64'(0));
    check_eq("len0_ww", 64'(words_written), 64'(0));
    repeat (3) @(negedge clk);
    check_eq("len0_hold", 64'(done), 64'(1));
    go = 1'b0;
    @(negedge clk);
    check_eq("len0_idle", 64'(done), 64'(0));
    check_eq("len0_no_traffic", 64'((src_seen - s0) + (dst_seen - d0)), 64'(0));

    dst_lat = 20;
    r0 = rd_done_n; w0 = wr_done_n;
    start_job(1'b0, 32'h1000, 32'd1, 32'h2000, 16'd8, 32'h0);
    k = 0;
    while (wr_done_n == w0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq("stall_first_write", 64'(wr_done_n - w0), 64'(1));
    check_eq("stall_reads", 64'(rd_done_n - r0), 64'(4));
    check_eq("stall_rd_idle", 64'(src_avail), 64'(0));
    wait_done(16'd8);
    dst_lat = 1;

    start_job(1'b0, 32'h40, 32'd2, 32'h80, 16'd6, 32'h0);
    k = 0;
    while (words_written != 16'd2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq("mid_ww", 64'(words_written), 64'(2));
    #2 rst_l = 1'b0;
    #1 check_zero("midrst");
    rd_q.delete();
    wr_q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    start_job(1'b0, 32'h600, 32'd1, 32'h700, 16'd2, 32'h0);
    wait_done(16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
